// File: rtl/div3_pkg.sv
// Shared types and default constants for the divisible-by-3 iterative block.
package div3_pkg;

   // Controller state encoding.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REDUCE = 2'd1,
      DONE   = 2'd2
   } div3_state_t;

   // Default geometry: 8-bit operand, depth register able to hold 8,
   // half-width for the alternating masks, counter able to hold log2(8).
   localparam int DEF_DATA_LEN  = 8;
   localparam int DEF_DEPTH_LEN = 4;
   localparam int DEF_HALF_LEN  = 4;
   localparam int DEF_ITER_W    = 3;

   // Reduction stops once the running value is at or below this.
   localparam int DIV3_THRESH   = 3;

endpackage : div3_pkg

// File: rtl/diff_even_odd.sv
// One reduction step: |popcount(even bits) - popcount(odd bits)| over the
// low i_cur_depth bits of i_data, plus the halved depth for the next step.
module diff_even_odd
   import div3_pkg::*;
#(
   parameter int DATA_LEN  = DEF_DATA_LEN,
   parameter int DEPTH_LEN = DEF_DEPTH_LEN,
   parameter int HALF_LEN  = DEF_HALF_LEN
) (
   input  logic [DATA_LEN-1:0]  i_data,
   input  logic [DEPTH_LEN-1:0] i_cur_depth,
   output logic [DATA_LEN-1:0]  o_diff,
   output logic [DEPTH_LEN-1:0] o_new_depth
);

   // Bit 0,2,4,... belong to the even set; bit 1,3,5,... to the odd set.
   localparam logic [DATA_LEN-1:0] EVEN_MASK = {HALF_LEN{2'b01}};
   localparam logic [DATA_LEN-1:0] ODD_MASK  = {HALF_LEN{2'b10}};

   logic [DATA_LEN-1:0]  w_depth_mask;
   logic [DATA_LEN-1:0]  w_even_bits;
   logic [DATA_LEN-1:0]  w_odd_bits;
   logic [DEPTH_LEN-1:0] w_even_cnt;
   logic [DEPTH_LEN-1:0] w_odd_cnt;

   // Keep only bits below the current depth; compares against i rather than
   // indexing depth-1, so depth 0 simply selects nothing.
   always_comb begin
      w_depth_mask = '0;
      for (int i = 0; i < DATA_LEN; i++) begin
         w_depth_mask[i] = (DEPTH_LEN'(i) < i_cur_depth);
      end
   end

   assign w_even_bits = i_data & w_depth_mask & EVEN_MASK;
   assign w_odd_bits  = i_data & w_depth_mask & ODD_MASK;

   // Population counts of the two masked sets (each at most DATA_LEN/2).
   always_comb begin
      w_even_cnt = '0;
      w_odd_cnt  = '0;
      for (int i = 0; i < DATA_LEN; i++) begin
         w_even_cnt = w_even_cnt + DEPTH_LEN'(w_even_bits[i]);
         w_odd_cnt  = w_odd_cnt  + DEPTH_LEN'(w_odd_bits[i]);
      end
   end

   // Unsigned magnitude of the difference, zero-extended to operand width.
   // Since 2^even == 1 and 2^odd == -1 (mod 3), this preserves divisibility.
   always_comb begin
      if (w_even_cnt >= w_odd_cnt) begin
         o_diff = DATA_LEN'(w_even_cnt - w_odd_cnt);
      end else begin
         o_diff = DATA_LEN'(w_odd_cnt - w_even_cnt);
      end
   end

   assign o_new_depth = i_cur_depth >> 1;

endmodule : diff_even_odd

// File: rtl/div3_iter_ctrl.sv
// Iterative divisible-by-3 controller: accepts one operand, reduces it one
// even/odd popcount-difference step per clock until it is <= 3, then
// presents the verdict and step count until the consumer takes it.
module div3_iter_ctrl
   import div3_pkg::*;
#(
   parameter int DATA_LEN  = DEF_DATA_LEN,
   parameter int DEPTH_LEN = DEF_DEPTH_LEN,
   parameter int HALF_LEN  = DEF_HALF_LEN,
   parameter int ITER_W    = DEF_ITER_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [DATA_LEN-1:0] in_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                out_div3,
   output logic [ITER_W-1:0]   out_iters
);

   localparam logic [DATA_LEN-1:0]  L_THRESH    = DATA_LEN'(DIV3_THRESH);
   localparam logic [DEPTH_LEN-1:0] L_FULL_DEPTH = DEPTH_LEN'(DATA_LEN);
   localparam logic [DEPTH_LEN-1:0] L_MIN_DEPTH  = DEPTH_LEN'(1);

   div3_state_t          r_state, w_state_nxt;
   logic [DATA_LEN-1:0]  r_value, w_value_nxt;
   logic [DEPTH_LEN-1:0] r_depth, w_depth_nxt;
   logic [ITER_W-1:0]    r_iters, w_iters_nxt;
   logic                 r_res,   w_res_nxt;

   logic [DATA_LEN-1:0]  w_diff;
   logic [DEPTH_LEN-1:0] w_new_depth;

   diff_even_odd #(
      .DATA_LEN  (DATA_LEN),
      .DEPTH_LEN (DEPTH_LEN),
      .HALF_LEN  (HALF_LEN)
   ) u_step (
      .i_data      (r_value),
      .i_cur_depth (r_depth),
      .o_diff      (w_diff),
      .o_new_depth (w_new_depth)
   );

   // State and datapath registers; reset discards any in-flight operand.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_value <= '0;
         r_depth <= '0;
         r_iters <= '0;
         r_res   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_value <= w_value_nxt;
         r_depth <= w_depth_nxt;
         r_iters <= w_iters_nxt;
         r_res   <= w_res_nxt;
      end
   end

   // Next-state and datapath update: capture, reduce, or hold the verdict.
   always_comb begin
      w_state_nxt = r_state;
      w_value_nxt = r_value;
      w_depth_nxt = r_depth;
      w_iters_nxt = r_iters;
      w_res_nxt   = r_res;
      case (r_state)
         IDLE: begin
            if (in_valid) begin
               w_value_nxt = in_data;
               w_depth_nxt = L_FULL_DEPTH;
               w_iters_nxt = '0;
               w_res_nxt   = 1'b0;
               w_state_nxt = REDUCE;
            end
         end
         REDUCE: begin
            if (r_value <= L_THRESH) begin
               // Residues 0 and 3 are the only multiples of 3 left.
               w_res_nxt   = (r_value == '0) || (r_value == L_THRESH);
               w_state_nxt = DONE;
            end else if (r_depth > L_MIN_DEPTH) begin
               w_value_nxt = w_diff;
               w_depth_nxt = w_new_depth;
               w_iters_nxt = r_iters + ITER_W'(1);
            end else begin
               // Cannot occur for a power-of-two width; fail closed.
               w_res_nxt   = 1'b0;
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign out_div3  = r_res;
   assign out_iters = r_iters;

endmodule : div3_iter_ctrl

// File: tb/tb_div3_iter_ctrl.sv
// Directed bench for div3_iter_ctrl: reset values, known vectors with
// latency, backpressure, async reset mid-operation and a full 8-bit sweep.
module tb_div3_iter_ctrl;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic       out_div3;
   logic [2:0] out_iters;

   int checks;
   int failures;

   div3_iter_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_div3  (out_div3),
      .out_iters (out_iters)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives one operand, waits (bounded) for the result, then handshakes it.
   // lat counts edges after the accepting edge until out_valid is seen.
   task automatic run_op(input logic [7:0] x, output logic d,
                         output logic [2:0] it, output int lat,
                         output bit to);
      @(negedge clk);
      in_valid  = 1'b1;
      in_data   = x;
      out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      to  = 1'b0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!out_valid) to = 1'b1;
      d  = out_div3;
      it = out_iters;
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      checks++;
      if (out_div3 !== 1'b0) begin failures++; $display("FAIL reset_out_div3 got %b want 0", out_div3); end
      checks++;
      if (out_iters !== 3'd0) begin failures++; $display("FAIL reset_out_iters got %0d want 0", out_iters); end
      @(negedge clk);
      rst = 1'b0;
      // out_ready while idle must not disturb anything.
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL idle_out_ready got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_vectors();
      logic [7:0] vec_d [8] = '{8'h99, 8'h55, 8'hAA, 8'h00, 8'h03, 8'h15, 8'h07, 8'hFF};
      logic       vec_v [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      int         vec_k [8] = '{1, 2, 2, 0, 0, 1, 1, 1};
      logic       d;
      logic [2:0] it;
      int         lat;
      bit         to;
      for (int n = 0; n < 8; n++) begin
         run_op(vec_d[n], d, it, lat, to);
         checks++;
         if (to) begin
            failures++;
            $display("FAIL vec_%02h timeout got no out_valid want out_valid", vec_d[n]);
         end
         checks++;
         if (d !== vec_v[n]) begin
            failures++;
            $display("FAIL vec_%02h div3 got %b want %b", vec_d[n], d, vec_v[n]);
         end
         checks++;
         if (int'(it) != vec_k[n]) begin
            failures++;
            $display("FAIL vec_%02h iters got %0d want %0d", vec_d[n], it, vec_k[n]);
         end
         checks++;
         if (lat != vec_k[n] + 1) begin
            failures++;
            $display("FAIL vec_%02h latency got %0d want %0d", vec_d[n], lat, vec_k[n] + 1);
         end
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      // 0x99 held in DONE under backpressure while 0x07 is offered.
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'h99; out_ready = 1'b0;
      @(posedge clk); #1;
      in_data = 8'h07;
      lat = 0;
      while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
      checks++;
      if (lat != 2) begin failures++; $display("FAIL bp_latency got %0d want 2", lat); end
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b1 || out_div3 !== 1'b1 || out_iters !== 3'd1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_hold cyc%0d got v=%b d=%b it=%0d rdy=%b want 1/1/1/0",
                     c, out_valid, out_div3, out_iters, in_ready);
         end
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL bp_release got v=%b rdy=%b want 0/1", out_valid, in_ready);
      end
      @(negedge clk);
      out_ready = 1'b0;
      @(posedge clk); #1;          // 0x07 accepted here
      in_valid = 1'b0;
      checks++;
      if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_accept2 got rdy=%b want 0", in_ready); end
      lat = 0;
      while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
      checks++;
      if (out_valid !== 1'b1 || out_div3 !== 1'b0 || out_iters !== 3'd1) begin
         failures++;
         $display("FAIL bp_second got v=%b d=%b it=%0d want 1/0/1", out_valid, out_div3, out_iters);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_rst_mid();
      int seen;
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'h55;
      @(posedge clk); #1;
      in_valid = 1'b0;
      #1 rst = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid_async got rdy=%b v=%b want 1/0", in_ready, out_valid);
      end
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      checks++;
      if (seen != 0) begin failures++; $display("FAIL rst_mid_ghost got %0d valid cycles want 0", seen); end
   endtask

   task automatic test_sweep();
      logic       d;
      logic [2:0] it;
      int         lat;
      bit         to;
      for (int x = 0; x < 256; x++) begin
         run_op(8'(x), d, it, lat, to);
         checks++;
         if (to || d !== ((x % 3) == 0)) begin
            failures++;
            $display("FAIL sweep_%0d got div3=%b timeout=%0d want div3=%0d", x, d, to, (x % 3) == 0);
         end
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_vectors();
      test_back_to_back();
      test_rst_mid();
      test_sweep();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_div3_iter_ctrl
